// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the pipeline and the HI/LO multiply/divide unit.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             iStart;
    logic [1:0]       iOp;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iMTHI;
    logic             iMTLO;
    logic             iCancel;
    logic [WIDTH-1:0] oHI;
    logic [WIDTH-1:0] oLO;
    logic             oBusy;
    logic             oDone;

    // Pipeline side: issues requests, observes HI/LO and status.
    modport master (
        output iStart, iOp, iA, iB, iMTHI, iMTLO, iCancel,
        input  oHI, oLO, oBusy, oDone
    );

    // Unit side.
    modport slave (
        input  iStart, iOp, iA, iB, iMTHI, iMTLO, iCancel,
        output oHI, oLO, oBusy, oDone
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, sign correction applied in a final cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic               iCLK,
    input logic               iRST,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    localparam int unsigned     CntW     = 6;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept, step, fix_wr, mt_ok;

    // Latched operation context.
    logic              op_div_q;
    logic              neg_a_q, neg_b_q;
    logic              zero_q;
    logic [WIDTH-1:0]  dvd_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0]  hi_q, lo_q;

    // Operand conditioning at accept.
    logic              signed_op, neg_a_in, neg_b_in;
    logic [WIDTH-1:0]  amag_in, bmag_in;

    // Iteration datapath.
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;

    // Sign-corrected results.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

    // FSM next-state and strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        step    = 1'b0;
        fix_wr  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.iStart) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.iCancel) begin
                    state_d = StIdle;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                // Cancel suppresses the write-back even in the final cycle.
                if (!bus.iCancel) begin
                    fix_wr = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        mt_ok  = (state_q == StIdle) && !bus.iStart;
    end

    // FSM state, counter and registered status outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Operand magnitudes, one iteration step, and final sign correction.
    always_comb begin
        signed_op = ~bus.iOp[0];
        neg_a_in  = signed_op & bus.iA[WIDTH-1];
        neg_b_in  = signed_op & bus.iB[WIDTH-1];
        amag_in   = neg_a_in ? -bus.iA : bus.iA;
        bmag_in   = neg_b_in ? -bus.iB : bus.iB;

        if (acc_q[0]) begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        end else begin
            mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end

        // Partial remainder shifted left with the next dividend bit from the low half.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});

        acc_d = acc_q;
        if (accept) begin
            // Low half holds the multiplier or the dividend; it shifts out as the result forms.
            acc_d = bus.iOp[1] ? {{WIDTH{1'b0}}, amag_in} : {{WIDTH{1'b0}}, bmag_in};
        end else if (step) begin
            if (op_div_q) begin
                if (div_ge) begin
                    acc_d = {WIDTH'(div_shift - {1'b0, opnd_q}), acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end

        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (!op_div_q) begin
            {hi_fix, lo_fix} = prod_fix;
        end else if (zero_q) begin
            // Divide by zero: raw dividend in HI, all-ones quotient.
            hi_fix = dvd_q;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    // Operation context latch and iteration accumulator.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            op_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            zero_q   <= 1'b0;
            dvd_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else begin
            if (accept) begin
                op_div_q <= bus.iOp[1];
                neg_a_q  <= neg_a_in;
                neg_b_q  <= neg_b_in;
                zero_q   <= (bus.iB == '0);
                dvd_q    <= bus.iA;
                opnd_q   <= bus.iOp[1] ? bmag_in : amag_in;
            end
            acc_q <= acc_d;
        end
    end

    // Architectural HI/LO: operation write-back, else direct moves when idle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (fix_wr) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
        end else if (mt_ok) begin
            if (bus.iMTHI) begin
                hi_q <= bus.iA;
            end
            if (bus.iMTLO) begin
                lo_q <= bus.iA;
            end
        end
    end

    assign bus.oHI   = hi_q;
    assign bus.oLO   = lo_q;
    assign bus.oBusy = busy_q;
    assign bus.oDone = done_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table plus multi-cycle corner sequences.
module tb_muldiv_sequencer;
    localparam int unsigned WIDTH = 32;

    logic iCLK = 1'b0;
    logic iRST;
    int   nvec = 0;
    int   nerr = 0;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.iStart  = 1'b0;
        bus.iOp     = 2'b00;
        bus.iA      = '0;
        bus.iB      = '0;
        bus.iMTHI   = 1'b0;
        bus.iMTLO   = 1'b0;
        bus.iCancel = 1'b0;
    endtask

    // One full operation: accept edge 0, results visible after edge 33.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string tag);
        int busy_cnt;
        @(negedge iCLK);
        bus.iStart = 1'b1;
        bus.iOp    = op;
        bus.iA     = a;
        bus.iB     = b;
        busy_cnt   = 0;
        for (int k = 0; k <= 32; k++) begin
            @(negedge iCLK);
            bus.iStart = 1'b0;
            bus.iA     = '0;
            bus.iB     = '0;
            if (bus.oBusy && !bus.oDone) busy_cnt++;
        end
        check({tag, "_busy_cycles"}, busy_cnt, 32'd33);
        @(negedge iCLK);
        check_bit({tag, "_done"}, bus.oDone, 1'b1);
        check_bit({tag, "_busy_off"}, bus.oBusy, 1'b0);
        check({tag, "_hi"}, bus.oHI, exp_hi);
        check({tag, "_lo"}, bus.oLO, exp_lo);
        @(negedge iCLK);
        check_bit({tag, "_done_pulse"}, bus.oDone, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;

        //        op     a             b             hi            lo
        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{2'b10, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
        vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};

        // Reset state, checked while reset is still asserted.
        iRST = 1'b1;
        drive_idle();
        #12;
        check("rst_hi", bus.oHI, 32'd0);
        check("rst_lo", bus.oLO, 32'd0);
        check_bit("rst_busy", bus.oBusy, 1'b0);
        check_bit("rst_done", bus.oDone, 1'b0);
        @(negedge iCLK);
        iRST = 1'b0;

        // MTHI in idle, then a cancelled DIVU with ignored MTLO and iStart.
        @(negedge iCLK);
        bus.iMTHI = 1'b1;
        bus.iA    = 32'h1234;
        @(negedge iCLK);
        bus.iMTHI = 1'b0;
        check("mthi_hi", bus.oHI, 32'h1234);
        check("mthi_lo", bus.oLO, 32'd0);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b11;
        bus.iA     = 32'd100;
        bus.iB     = 32'd7;
        done_cnt   = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge iCLK);
            if (bus.oDone) done_cnt++;
            if (k == 20) check_bit("cancel_busy_before", bus.oBusy, 1'b1);
            if (k == 21) begin
                check_bit("cancel_busy_after", bus.oBusy, 1'b0);
                check("cancel_hi", bus.oHI, 32'h1234);
                check("cancel_lo", bus.oLO, 32'd0);
            end
            bus.iStart  = (k == 10);
            bus.iOp     = 2'b00;
            bus.iA      = 32'hBEEF;
            bus.iB      = 32'd3;
            bus.iMTLO   = (k == 5);
            bus.iCancel = (k == 20);
        end
        check("cancel_no_done", done_cnt, 32'd0);
        check_bit("cancel_stay_idle", bus.oBusy, 1'b0);
        check("cancel_lo_final", bus.oLO, 32'd0);
        drive_idle();

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i));
        end

        // Cancel during FIX beats the write-back.
        @(negedge iCLK);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b00;
        bus.iA     = 32'd5;
        bus.iB     = 32'd5;
        for (int k = 0; k <= 34; k++) begin
            @(negedge iCLK);
            bus.iStart  = 1'b0;
            bus.iCancel = (k == 32);
            if (k == 32) check_bit("fixcan_busy_in_fix", bus.oBusy, 1'b1);
            if (k == 33) begin
                check_bit("fixcan_busy", bus.oBusy, 1'b0);
                check_bit("fixcan_done", bus.oDone, 1'b0);
                check("fixcan_hi", bus.oHI, 32'd5);
                check("fixcan_lo", bus.oLO, 32'h19999999);
            end
            if (k == 34) check_bit("fixcan_done_late", bus.oDone, 1'b0);
        end
        drive_idle();

        // iCancel in idle does not block an accept.
        @(negedge iCLK);
        bus.iStart  = 1'b1;
        bus.iCancel = 1'b1;
        bus.iOp     = 2'b01;
        bus.iA      = 32'd2;
        bus.iB      = 32'd3;
        for (int k = 0; k <= 33; k++) begin
            @(negedge iCLK);
            if (k == 0) check_bit("idlecan_accept", bus.oBusy, 1'b1);
            if (k == 33) begin
                check_bit("idlecan_done", bus.oDone, 1'b1);
                check("idlecan_hi", bus.oHI, 32'd0);
                check("idlecan_lo", bus.oLO, 32'd6);
            end
            drive_idle();
        end

        // Start beats simultaneous MTHI/MTLO; then reset mid-run.
        @(negedge iCLK);
        bus.iStart = 1'b1;
        bus.iMTHI  = 1'b1;
        bus.iMTLO  = 1'b1;
        bus.iOp    = 2'b01;
        bus.iA     = 32'd3;
        bus.iB     = 32'd4;
        for (int k = 0; k <= 15; k++) begin
            @(negedge iCLK);
            drive_idle();
            if (k == 0) begin
                check("startwin_hi", bus.oHI, 32'd0);
                check("startwin_lo", bus.oLO, 32'd6);
            end
        end
        iRST = 1'b1;
        #1;
        check("midrst_hi", bus.oHI, 32'd0);
        check("midrst_lo", bus.oLO, 32'd0);
        check_bit("midrst_busy", bus.oBusy, 1'b0);
        check_bit("midrst_done", bus.oDone, 1'b0);
        #1;
        iRST = 1'b0;
        run_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "postrst");

        // Back-to-back with iStart held: second accept in the oDone cycle.
        @(negedge iCLK);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b01;
        bus.iA     = 32'd3;
        bus.iB     = 32'd5;
        for (int k = 0; k <= 68; k++) begin
            @(negedge iCLK);
            if (k == 0) begin
                bus.iA = 32'd6;
                bus.iB = 32'd7;
            end
            if (k == 33) begin
                check_bit("b2b_done1", bus.oDone, 1'b1);
                check("b2b_lo1", bus.oLO, 32'd15);
                check("b2b_hi1", bus.oHI, 32'd0);
            end
            if (k == 34) begin
                check_bit("b2b_accept2", bus.oBusy, 1'b1);
                check_bit("b2b_done_clr", bus.oDone, 1'b0);
            end
            if (k == 67) begin
                check_bit("b2b_done2", bus.oDone, 1'b1);
                check("b2b_lo2", bus.oLO, 32'd42);
                check("b2b_hi2", bus.oHI, 32'd0);
                bus.iStart = 1'b0;
            end
            if (k == 68) begin
                check_bit("b2b_idle", bus.oBusy, 1'b0);
                check_bit("b2b_done_end", bus.oDone, 1'b0);
            end
        end
        drive_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width; only 32 is supported and verified.
REQ-002 The block SHALL have port iCLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iRST, input, 1 bit, reset, asynchronous and active-high.
REQ-004 The block SHALL have port iStart, input, 1 bit, the request to begin the operation selected by iOp.
REQ-005 The block SHALL have port iOp, input, 2 bits, the operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports iA and iB, input, WIDTH bits each: the multiplicand/dividend and the multiplier/divisor.
REQ-007 The block SHALL have ports iMTHI and iMTLO, input, 1 bit each, the direct-write strobes for HI and LO.
REQ-008 The block SHALL have port iCancel, input, 1 bit, which aborts an in-flight operation (exception flush).
REQ-009 The block SHALL have ports oHI and oLO, output, WIDTH bits each, the architectural HI and LO registers.
REQ-010 The block SHALL have port oBusy, output, 1 bit, high while an operation is in flight; the pipeline stalls on it.
REQ-011 The block SHALL have port oDone, output, 1 bit, a one-cycle pulse marking that HI/LO were just written by an operation.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and FIX, with a 6-bit iteration counter.
REQ-013 In IDLE with iStart=1, the block SHALL latch iOp, iA and iB, record the operand signs, load the operand magnitudes (signed ops only), clear the counter, and go to RUN.
REQ-014 RUN SHALL perform one iteration per cycle for 32 cycles (counter 0..31), then go to FIX.
- Multiply: shift-add, one iteration per cycle.
- Divide: restoring, one quotient bit per cycle.
REQ-015 In FIX the block SHALL apply sign correction, write HI/LO, and go to IDLE; oDone SHALL be 1 in the cycle after FIX.
REQ-016 Latency: with the accept edge as edge 0, new HI/LO SHALL be visible after edge 33, with oDone high during that same cycle.
REQ-017 oBusy SHALL be 1 exactly while the state is RUN or FIX; it is a registered output.
REQ-018 MULT/MULTU SHALL produce the 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
- MULT: the product is negated if the operand signs differ.
REQ-019 DIV/DIVU SHALL set LO = quotient and HI = remainder.
- DIV: quotient truncates toward zero; the quotient is negated if the signs differ; the remainder takes the dividend's sign.
REQ-020 Divide by zero (iB=0) SHALL still run the full latency and yield HI = dividend and LO = 0xFFFFFFFF, for both DIV and DIVU.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO = 0x80000000 and HI = 0.
REQ-022 iStart SHALL be ignored while oBusy=1; no queuing.
REQ-023 iMTHI/iMTLO SHALL write iA into HI/LO at the edge only in IDLE with iStart=0, and SHALL be ignored otherwise.
- If iStart=1 in the same cycle, the operation wins.
- iMTHI and iMTLO together SHALL write both registers.
REQ-024 iCancel=1 in RUN or FIX SHALL return the FSM to IDLE at the next edge.
- HI/LO SHALL be unchanged and no oDone pulse SHALL be produced.
- iCancel SHALL have no effect in IDLE.
REQ-025 iCancel SHALL take priority over the FIX write in the same cycle.
REQ-026 A new iStart SHALL be accepted in the cycle oDone is high.

Reset
REQ-027 iRST=1 SHALL asynchronously force the state to IDLE, the counter to 0, oHI = oLO = 0, oBusy = 0 and oDone = 0.
REQ-028 Reset mid-operation SHALL discard the operation; after release the block SHALL be idle and accept iStart on the first edge.

Verification
REQ-029 MULT with iA=0xFFFFFFFD (-3) and iB=5 -> at edge 33: HI=0xFFFFFFFF, LO=0xFFFFFFF1; oDone one cycle; oBusy high for 33 cycles.
REQ-030 MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 DIV with 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI=7, LO=0xFFFFFFFF.
REQ-032 Sequence: MTHI with iA=0x1234 in IDLE -> HI=0x1234. Then start DIVU 100/7, assert iMTLO at RUN cycle 5, iStart at cycle 10, and iCancel at cycle 20 -> MTLO and iStart ignored; state IDLE; HI=0x1234, LO=0; no oDone.
REQ-033 iRST pulse at RUN cycle 15 of MULTU 3x4 -> outputs 0 immediately; a subsequent MULTU 3x4 -> LO=12, HI=0.
REQ-034 Back-to-back: iStart held high -> second operation accepted in the oDone cycle, with its results 34 cycles after the first.
